// File: rtl/demorgan_sweep.sv
// Registered WIDTH-bit De Morgan logic unit with an exhaustive self-check sweep.
// Optional macro DEMORGAN_FAULT_INJECT_EN adds a fault_inject input that flips bit 0 of AnorB.
//
// state | meaning
// IDLE  | accepts start / external operands
// SWEEP | captures one counter-generated operand pair per cycle
// DRAIN | last swept vector moves through the result register
// DONE  | final check lands; done pulses on the following cycle
module demorgan_sweep #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic             in_valid,
`ifdef DEMORGAN_FAULT_INJECT_EN
   input  logic             fault_inject,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] nA,
   output logic [WIDTH-1:0] nB,
   output logic [WIDTH-1:0] nAandnB,
   output logic [WIDTH-1:0] AnandB,
   output logic [WIDTH-1:0] nAornB,
   output logic [WIDTH-1:0] AnorB,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [2*WIDTH:0] mismatch_count,
   output logic             pass
);

   localparam int CW = 2 * WIDTH;
   localparam int MW = 2 * WIDTH + 1;
   localparam logic [CW-1:0] CNT_LAST = '1;
   localparam logic [MW-1:0] MIS_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             capture;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;
   logic             clear_mis;
   logic             idle_ready;

   logic             op_valid;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   logic [WIDTH-1:0] r_na;
   logic [WIDTH-1:0] r_nb;
   logic [WIDTH-1:0] r_nand_n;
   logic [WIDTH-1:0] r_nand;
   logic [WIDTH-1:0] r_nor_n;
   logic [WIDTH-1:0] r_nor;
   logic [WIDTH-1:0] fault_mask;
   logic             violation;

`ifdef DEMORGAN_FAULT_INJECT_EN
   always_comb begin
      fault_mask    = '0;
      fault_mask[0] = fault_inject;
   end
`else
   assign fault_mask = '0;
`endif

   // The done pulse cycle is treated as part of DONE: no new command is taken there.
   assign idle_ready = (state == IDLE) && !done;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      cap_a     = a_in;
      cap_b     = b_in;
      clear_mis = 1'b0;
      case (state)
         IDLE: begin
            if (idle_ready && start) begin
               clear_mis = 1'b1;
               cnt_nxt   = '0;
               if (mode) begin
                  state_nxt = SWEEP;
               end
            end else if (idle_ready && in_valid) begin
               capture = 1'b1;
            end
         end
         SWEEP: begin
            capture = 1'b1;
            cap_a   = cnt[CW-1:WIDTH];
            cap_b   = cnt[WIDTH-1:0];
            cnt_nxt = cnt + CW'(1);
            if (cnt == CNT_LAST) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         op_valid <= capture;
         if (capture) begin
            op_a <= cap_a;
            op_b <= cap_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_na      <= '0;
         r_nb      <= '0;
         r_nand_n  <= '0;
         r_nand    <= '0;
         r_nor_n   <= '0;
         r_nor     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= op_valid;
         if (op_valid) begin
            r_na     <= ~op_a;
            r_nb     <= ~op_b;
            r_nand_n <= ~op_a & ~op_b;
            r_nand   <= ~(op_a & op_b);
            r_nor_n  <= ~op_a | ~op_b;
            r_nor    <= ~(op_a | op_b);
         end
      end
   end

   assign nA      = r_na;
   assign nB      = r_nb;
   assign nAandnB = r_nand_n;
   assign AnandB  = r_nand;
   assign nAornB  = r_nor_n;
   assign AnorB   = r_nor ^ fault_mask;

   // Checker looks at the bus values that actually leave the block, fault included.
   assign violation = |((nAandnB ^ AnorB) | (AnandB ^ nAornB));

   always_ff @(posedge clk) begin
      if (reset) begin
         mismatch_count <= '0;
         done           <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (clear_mis) begin
            mismatch_count <= '0;
         end else if (out_valid && violation && (mismatch_count != MIS_MAX)) begin
            mismatch_count <= mismatch_count + MW'(1);
         end
      end
   end

   assign busy = (state == SWEEP) || (state == DRAIN);
   assign pass = (mismatch_count == '0);

endmodule
